// File: rtl/arf_commit_seq.sv
// arf_commit_seq: serialises up to two ROB commits per cycle onto the single ARF write port via a small FIFO.
// Optional ARF_SEQ_PERF_EN adds stall-cycle and occupancy high-water-mark counters.
module arf_commit_seq #(
    parameter int REG_SEL  = 5,
    parameter int RRF_SEL  = 6,
    parameter int DATA_LEN = 32,
    parameter int DEPTH    = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      com1_valid_i,
    input  logic [REG_SEL-1:0]        com1_dst_num_i,
    input  logic [RRF_SEL-1:0]        com1_rrftag_i,
    input  logic [DATA_LEN-1:0]       com1_data_i,
    input  logic                      com2_valid_i,
    input  logic [REG_SEL-1:0]        com2_dst_num_i,
    input  logic [RRF_SEL-1:0]        com2_rrftag_i,
    input  logic [DATA_LEN-1:0]       com2_data_i,
    output logic                      com_ready_o,
    output logic                      arf_we_o,
    output logic [REG_SEL-1:0]        arf_dst_num_o,
    output logic [RRF_SEL-1:0]        arf_rrftag_o,
    output logic [DATA_LEN-1:0]       arf_data_o,
    output logic                      idle_o,
    output logic                      err_o
`ifdef ARF_SEQ_PERF_EN
    ,
    output logic [31:0]               perf_stall_cnt_o,
    output logic [$clog2(DEPTH):0]    perf_max_occ_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = REG_SEL + RRF_SEL + DATA_LEN;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          v1, v2, pop;
    logic [1:0]    n_enq;

    always_comb begin
        v1          = com1_valid_i && (com1_dst_num_i != '0);
        v2          = com2_valid_i && (com2_dst_num_i != '0);
        com_ready_o = count_q <= CW'(DEPTH - 2);
        pop         = count_q != '0;
        n_enq       = com_ready_o ? {1'b0, v1} + {1'b0, v2} : 2'd0;
        mem_d       = mem_q;
        // com2 lands behind com1 when both are real commits, keeping program order
        if (com_ready_o && v1) mem_d[wr_ptr_q] = {com1_dst_num_i, com1_rrftag_i, com1_data_i};
        if (com_ready_o && v2) mem_d[wr_ptr_q + PW'(v1)] = {com2_dst_num_i, com2_rrftag_i, com2_data_i};
        wr_ptr_d    = wr_ptr_q + PW'(n_enq);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        count_d     = count_q + CW'(n_enq) - CW'(pop);
        err_d       = err_q | (!com_ready_o & (v1 | v2));
        arf_we_o    = pop;
        {arf_dst_num_o, arf_rrftag_o, arf_data_o} = pop ? mem_q[rd_ptr_q] : '0;
        idle_o      = !pop & !com1_valid_i & !com2_valid_i;
        err_o       = err_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_i) mem_q <= mem_d;

`ifdef ARF_SEQ_PERF_EN
    logic [31:0]   stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] max_occ_q, max_occ_d;

    always_comb begin
        stall_cnt_d      = (!com_ready_o && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
        max_occ_d        = count_d > max_occ_q ? count_d : max_occ_q;
        perf_stall_cnt_o = stall_cnt_q;
        perf_max_occ_o   = max_occ_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            stall_cnt_q <= '0;
            max_occ_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            max_occ_q   <= max_occ_d;
        end
    end
`endif
endmodule
